// File: rtl/pc_fetch_pkg.sv
// Shared types for the PC fetch sequencer.
//   XLEN          : default datapath width
//   fetch_state_e : sequencer states
//   redir_src_e   : redirect sources, encoded in ascending priority so that
//                   a plain numeric compare orders them
//   redir_t       : a redirect record {valid, src, target}
package pc_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StBoot,
    StIdle,
    StFetch
  } fetch_state_e;

  typedef enum logic [1:0] {
    RedirNone   = 2'd0,
    RedirBranch = 2'd1,
    RedirMret   = 2'd2,
    RedirTrap   = 2'd3
  } redir_src_e;

  typedef struct packed {
    logic             valid;
    redir_src_e       src;
    logic [XLEN-1:0]  target;
  } redir_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter.
// Picks the highest-priority live redirect input (trap > mret > branch),
// word-aligns its target, then compares it against the pending redirect:
// the input wins when its priority is higher than or equal to the pending one.
// Ports:
//   trap_i/trap_vec_i, mret_i/mepc_i, branch_i/branch_tgt_i : redirect inputs
//   pend_valid_i, pend_src_i, pend_tgt_i                    : pending redirect
//   in_valid_o                                              : any input redirect live
//   sel_valid_o, sel_src_o, sel_tgt_o                       : winning redirect
module pc_redirect_arb #(
  parameter int unsigned XLEN = 32
) (
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_tgt_i,
  input  logic            pend_valid_i,
  input  logic [1:0]      pend_src_i,
  input  logic [XLEN-1:0] pend_tgt_i,
  output logic            in_valid_o,
  output logic            sel_valid_o,
  output logic [1:0]      sel_src_o,
  output logic [XLEN-1:0] sel_tgt_o
);
  import pc_fetch_pkg::*;

  logic [1:0]      in_src;
  logic [XLEN-1:0] in_raw;
  logic [XLEN-1:0] in_tgt;

  always_comb begin
    in_src = RedirNone;
    in_raw = '0;
    if (trap_i) begin
      in_src = RedirTrap;
      in_raw = trap_vec_i;
    end else if (mret_i) begin
      in_src = RedirMret;
      in_raw = mepc_i;
    end else if (branch_i) begin
      in_src = RedirBranch;
      in_raw = branch_tgt_i;
    end
    in_tgt     = {in_raw[XLEN-1:2], 2'b00};
    in_valid_o = (in_src != RedirNone);

    if (in_valid_o && (!pend_valid_i || (in_src >= pend_src_i))) begin
      sel_valid_o = 1'b1;
      sel_src_o   = in_src;
      sel_tgt_o   = in_tgt;
    end else begin
      sel_valid_o = pend_valid_i;
      sel_src_o   = pend_src_i;
      sel_tgt_o   = pend_tgt_i;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer for the 3-stage pipeline.
// Chooses the next PC, drives the PC register write-enable, runs the imem
// request/ack handshake with a timeout, and squashes wrong-path fetches.
// Ports:
//   clk_i, rst_ni                     : clock, async active-low reset
//   stall_i                           : downstream cannot accept an instruction
//   branch_taken_i/branch_target_i    : execute-stage redirect
//   trap_req_i/trap_vec_i             : trap redirect (highest priority)
//   mret_i/mepc_i                     : trap return redirect
//   pc_cur_i                          : PC register output
//   pc_next_o, pc_we_o                : PC register input and enable
//   imem_req_o, imem_addr_o, imem_ack_i : instruction memory handshake
//   instr_valid_o                     : fetched word may be captured by IF/DE
//   flush_o                           : squash IF/DE and DE/EX
//   fetch_fault_o                     : one-cycle pulse on fetch timeout
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN      = pc_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     TIMEOUT   = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] pc_cur_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_we_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  output logic            instr_valid_o,
  output logic            flush_o,
  output logic            fetch_fault_o
);
  import pc_fetch_pkg::*;

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  fetch_state_e    state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic [1:0]      pend_src_q, pend_src_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            in_valid;
  logic            sel_valid;
  logic [1:0]      sel_src;
  logic [XLEN-1:0] sel_tgt;

  pc_redirect_arb #(
    .XLEN(XLEN)
  ) u_arb (
    .trap_i       (trap_req_i),
    .trap_vec_i   (trap_vec_i),
    .mret_i       (mret_i),
    .mepc_i       (mepc_i),
    .branch_i     (branch_taken_i),
    .branch_tgt_i (branch_target_i),
    .pend_valid_i (pend_valid_q),
    .pend_src_i   (pend_src_q),
    .pend_tgt_i   (pend_tgt_q),
    .in_valid_o   (in_valid),
    .sel_valid_o  (sel_valid),
    .sel_src_o    (sel_src),
    .sel_tgt_o    (sel_tgt)
  );

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_src_d    = pend_src_q;
    pend_tgt_d    = pend_tgt_q;
    cnt_d         = cnt_q;
    pc_next_o     = pc_cur_i;
    pc_we_o       = 1'b0;
    imem_req_o    = 1'b0;
    imem_addr_o   = '0;
    instr_valid_o = 1'b0;
    fetch_fault_o = 1'b0;
    flush_o       = in_valid;

    unique case (state_q)
      StBoot: begin
        pc_next_o = RESET_VEC;
        pc_we_o   = 1'b1;
        state_d   = stall_i ? StIdle : StFetch;
      end

      StIdle: begin
        if (sel_valid) begin
          pc_next_o    = sel_tgt;
          pc_we_o      = 1'b1;
          pend_valid_d = 1'b0;
          pend_src_d   = RedirNone;
        end
        state_d = stall_i ? StIdle : StFetch;
      end

      StFetch: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_cur_i;
        if (imem_ack_i) begin
          // Ack outranks a simultaneous timeout.
          cnt_d = '0;
          if (sel_valid) begin
            pc_next_o    = sel_tgt;
            pc_we_o      = 1'b1;
            pend_valid_d = 1'b0;
            pend_src_d   = RedirNone;
          end else if (!stall_i) begin
            pc_next_o     = pc_cur_i + XLEN'(4);
            pc_we_o       = 1'b1;
            instr_valid_o = 1'b1;
          end
          // With stall and no redirect the PC holds, so IDLE refetches it.
          state_d = stall_i ? StIdle : StFetch;
        end else if (cnt_q == CntLast) begin
          imem_req_o    = 1'b0;
          fetch_fault_o = 1'b1;
          pc_next_o     = {trap_vec_i[XLEN-1:2], 2'b00};
          pc_we_o       = 1'b1;
          pend_valid_d  = 1'b0;
          pend_src_d    = RedirNone;
          cnt_d         = '0;
          state_d       = stall_i ? StIdle : StFetch;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // The arbiter already keeps the pending entry when the new input
          // is of lower priority, so latching its choice is sufficient.
          if (in_valid) begin
            pend_valid_d = sel_valid;
            pend_src_d   = sel_src;
            pend_tgt_d   = sel_tgt;
          end
        end
      end

      default: state_d = StBoot;
    endcase

    // Outputs are forced idle while reset is held so an outstanding imem
    // request is dropped without waiting for a clock edge.
    if (!rst_ni) begin
      pc_next_o     = RESET_VEC;
      pc_we_o       = 1'b0;
      imem_req_o    = 1'b0;
      imem_addr_o   = '0;
      instr_valid_o = 1'b0;
      flush_o       = 1'b0;
      fetch_fault_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StBoot;
      pend_valid_q <= 1'b0;
      pend_src_q   <= RedirNone;
      pend_tgt_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_src_q   <= pend_src_d;
      pend_tgt_q   <= pend_tgt_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a table of single-cycle ack vectors
// plus hand-written multi-cycle sequences. Inputs change on the falling edge
// and outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        flush;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .trap_req_i      (trap_req),
    .trap_vec_i      (trap_vec),
    .mret_i          (mret),
    .mepc_i          (mepc),
    .pc_cur_i        (pc_cur),
    .pc_next_o       (pc_next),
    .pc_we_o         (pc_we),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .instr_valid_o   (instr_valid),
    .flush_o         (flush),
    .fetch_fault_o   (fetch_fault)
  );

  typedef struct {
    logic        br;
    logic [31:0] br_tgt;
    logic        mr;
    logic [31:0] mr_tgt;
    logic        tr;
    logic [31:0] tr_vec;
    logic [31:0] pc;
    logic [31:0] exp_next;
    logic        exp_iv;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    trap_req      = 1'b0;
    trap_vec      = '0;
    mret          = 1'b0;
    mepc          = '0;
    imem_ack      = 1'b0;
  endtask

  // Start a new cycle: wait for the falling edge and clear the inputs.
  task automatic next_cyc();
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h0,  32'h0000_0100,
                32'h0000_0104, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h0,  32'hFFFF_FFFC,
                32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h203,   1'b0, 32'h0,     1'b0, 32'h0,  32'h0000_0010,
                32'h0000_0200, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h200,   1'b1, 32'h307,   1'b0, 32'h0,  32'h0000_0010,
                32'h0000_0304, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h200,   1'b1, 32'h300,   1'b1, 32'h81, 32'h0000_0010,
                32'h0000_0080, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h200,   1'b0, 32'h0,     1'b1, 32'h92, 32'h0000_0010,
                32'h0000_0090, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0,     1'b1, 32'h1001,  1'b0, 32'h0,  32'h0000_0010,
                32'h0000_1000, 1'b0, 1'b1};

    clr_in();
    pc_cur = '0;
    rst_n  = 1'b0;

    // Reset state, with a redirect input driven to show outputs stay quiet.
    branch_taken = 1'b1;
    #3;
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_pc_we", {31'b0, pc_we}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_iv", {31'b0, instr_valid}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    @(posedge clk);
    next_cyc();
    rst_n = 1'b1;
    #1;
    chk("boot_we", {31'b0, pc_we}, 32'h1);
    chk("boot_next", pc_next, 32'h0);
    chk("boot_req", {31'b0, imem_req}, 32'h0);

    // Back-to-back fetch with zero-wait memory.
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      pc_cur   = 32'(i * 4);
      imem_ack = 1'b1;
      #1;
      chk("seq_req", {31'b0, imem_req}, 32'h1);
      chk("seq_iv", {31'b0, instr_valid}, 32'h1);
      chk("seq_next", pc_next, 32'(i * 4 + 4));
    end

    // Table: one ack cycle per vector, FETCH with stall low.
    for (int i = 0; i < 7; i++) begin
      next_cyc();
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].br_tgt;
      mret          = vecs[i].mr;
      mepc          = vecs[i].mr_tgt;
      trap_req      = vecs[i].tr;
      trap_vec      = vecs[i].tr_vec;
      pc_cur        = vecs[i].pc;
      imem_ack      = 1'b1;
      #1;
      chk($sformatf("vec%0d_next", i), pc_next, vecs[i].exp_next);
      chk($sformatf("vec%0d_we", i), {31'b0, pc_we}, 32'h1);
      chk($sformatf("vec%0d_iv", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_iv});
      chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
    end

    // Delayed ack: address held, PC write only on the ack cycle.
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      pc_cur   = 32'h100;
      imem_ack = (i == 3);
      #1;
      chk("dly_req", {31'b0, imem_req}, 32'h1);
      chk("dly_addr", imem_addr, 32'h100);
      chk("dly_we", {31'b0, pc_we}, (i == 3) ? 32'h1 : 32'h0);
    end
    chk("dly_next", pc_next, 32'h104);

    // Redirects during an outstanding fetch are held and applied on ack;
    // a later lower-priority branch must not displace the pending trap.
    next_cyc();
    pc_cur        = 32'h104;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    #1;
    chk("pend_c1_flush", {31'b0, flush}, 32'h1);
    chk("pend_c1_we", {31'b0, pc_we}, 32'h0);
    next_cyc();
    pc_cur   = 32'h104;
    trap_req = 1'b1;
    trap_vec = 32'h80;
    #1;
    chk("pend_c2_flush", {31'b0, flush}, 32'h1);
    next_cyc();
    pc_cur        = 32'h104;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    #1;
    chk("pend_c3_we", {31'b0, pc_we}, 32'h0);
    next_cyc();
    pc_cur   = 32'h104;
    imem_ack = 1'b1;
    #1;
    chk("pend_ack_flush", {31'b0, flush}, 32'h0);
    chk("pend_ack_next", pc_next, 32'h80);
    chk("pend_ack_we", {31'b0, pc_we}, 32'h1);
    chk("pend_ack_iv", {31'b0, instr_valid}, 32'h0);
    next_cyc();
    pc_cur   = 32'h80;
    imem_ack = 1'b1;
    #1;
    chk("pend_clr_next", pc_next, 32'h84);
    chk("pend_clr_iv", {31'b0, instr_valid}, 32'h1);

    // Timeout: 16 cycles without ack.
    for (int i = 1; i <= 16; i++) begin
      next_cyc();
      pc_cur   = 32'h500;
      trap_vec = 32'h43;
      #1;
      if (i < 16) begin
        chk("to_wait_fault", {31'b0, fetch_fault}, 32'h0);
        chk("to_wait_req", {31'b0, imem_req}, 32'h1);
      end else begin
        chk("to_fault", {31'b0, fetch_fault}, 32'h1);
        chk("to_next", pc_next, 32'h40);
        chk("to_we", {31'b0, pc_we}, 32'h1);
        chk("to_req", {31'b0, imem_req}, 32'h0);
      end
    end

    // Ack on the would-be timeout cycle wins.
    for (int i = 1; i <= 16; i++) begin
      next_cyc();
      pc_cur   = 32'h40;
      trap_vec = 32'h43;
      imem_ack = (i == 16);
      #1;
      if (i == 1) chk("to2_restart_req", {31'b0, imem_req}, 32'h1);
    end
    chk("ackto_fault", {31'b0, fetch_fault}, 32'h0);
    chk("ackto_iv", {31'b0, instr_valid}, 32'h1);
    chk("ackto_next", pc_next, 32'h44);

    // Stall on the ack cycle: no advance, IDLE, then refetch the same PC.
    next_cyc();
    pc_cur   = 32'h20;
    imem_ack = 1'b1;
    stall    = 1'b1;
    #1;
    chk("stl_we", {31'b0, pc_we}, 32'h0);
    chk("stl_iv", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      pc_cur = 32'h20;
      stall  = (i == 0);
      #1;
      chk("stl_idle_req", {31'b0, imem_req}, 32'h0);
      chk("stl_idle_we", {31'b0, pc_we}, 32'h0);
    end
    next_cyc();
    pc_cur   = 32'h20;
    imem_ack = 1'b1;
    #1;
    chk("stl_refetch_addr", imem_addr, 32'h20);
    chk("stl_refetch_next", pc_next, 32'h24);

    // Reset in the middle of a request that has a pending redirect.
    next_cyc();
    pc_cur        = 32'h24;
    branch_taken  = 1'b1;
    branch_target = 32'h700;
    next_cyc();
    pc_cur = 32'h24;
    #1;
    chk("mid_req", {31'b0, imem_req}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    next_cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_boot_we", {31'b0, pc_we}, 32'h1);
    chk("mid_boot_next", pc_next, 32'h0);
    next_cyc();
    pc_cur   = 32'h0;
    imem_ack = 1'b1;
    #1;
    chk("mid_post_next", pc_next, 32'h4);
    chk("mid_post_iv", {31'b0, instr_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer for the PC register in the 3-stage pipeline. It chooses the next PC, asserts the PC write-enable, runs the instruction-memory request/ack handshake, and squashes wrong-path fetches. Redirect priority is trap > mret > branch > sequential. The block drives the pc register's pc_in and en inputs, and reads back the pc register's pc_out as pc_cur.

Parameters:
XLEN, 32, datapath width.
RESET_VEC, 32'h0000_0000, first fetch address after reset.
TIMEOUT, 16, maximum cycles an imem request may remain un-acked before a fault; must be at least 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low: rst==0 resets the block.
stall  in  1  hazard unit: downstream cannot accept an instruction.
branch_taken  in  1  execute stage: taken branch or jump this cycle.
branch_target  in  XLEN  branch/jump target.
trap_req  in  1  trap request (ecall, ebreak, illegal instruction).
trap_vec  in  XLEN  trap vector (mtvec).
mret  in  1  return from trap.
mepc  in  XLEN  return address.
pc_cur  in  XLEN  current PC from the pc register.
pc_next  out  XLEN  next PC, connects to pc_in.
pc_we  out  1  PC write-enable, connects to pc en (zero-extended).
imem_req  out  1  instruction fetch request.
imem_addr  out  XLEN  fetch address.
imem_ack  in  1  imem: data valid this cycle.
instr_valid  out  1  fetched word is good; IF/DE register may capture it.
flush  out  1  squash the IF/DE and DE/EX registers.
fetch_fault  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- States: BOOT, IDLE, FETCH. Internal registers: pending-redirect (valid, target), wait counter of width clog2(TIMEOUT+1).
- Reset (rst==0, asynchronous): state goes to BOOT, pending is cleared, counter goes to 0. All outputs are 0 except pc_next, which is RESET_VEC.
- BOOT: pc_next=RESET_VEC, pc_we=1, imem_req=0, for exactly one cycle. Next state is FETCH, or IDLE if stall=1.
- Redirect source select: the highest-priority active input among trap_req, mret, branch_taken. Target bits [1:0] are forced to 0.
- flush = trap_req | mret | branch_taken, combinational, in every state including BOOT.
- IDLE:
  - imem_req=0.
  - If a redirect input or pending is active: pc_next=target, pc_we=1, clear pending.
  - Next state is FETCH if stall=0, else remain in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc_cur. imem_addr stays stable until ack. pc_we=0 until ack.
  - The counter increments each cycle without ack.
  - A redirect arriving without ack is latched into pending. A higher-or-equal-priority later redirect overwrites pending; a lower-priority one does not.
- FETCH, on the ack cycle:
  - Redirect active (input or pending): pc_next=target, pc_we=1, instr_valid=0, clear pending. An input redirect outranks pending only if its priority is higher or equal.
  - Else if stall=1: pc_we=0, instr_valid=0, go to IDLE. The same PC is refetched later.
  - Else: pc_next=pc_cur+4 (modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0), pc_we=1, instr_valid=1.
  - Counter goes to 0. Next state is FETCH if stall=0, else IDLE.
- Zero-wait memory: ack in the first FETCH cycle gives one instruction per cycle.
- Timeout: counter==TIMEOUT-1 with no ack causes the following:
  - fetch_fault=1, pc_next=trap_vec & ~3, pc_we=1, imem_req is deasserted.
  - Pending is cleared and the counter goes to 0.
  - Next state is IDLE if stall=1, else FETCH.
- Ack and timeout in the same cycle: ack wins.
- Redirect input and ack in the same cycle: the redirect is applied directly and is not latched.
- Reset mid-request: imem_req drops asynchronously. The memory side must tolerate an abandoned request.

Decomposition:
- Package pc_fetch_pkg: XLEN constant, fetch_state_e {BOOT, IDLE, FETCH}, redir_src_e {NONE, BRANCH, MRET, TRAP} ordered by priority, and the redirect struct {valid, src, target}.
- One combinational sub-module, pc_redirect_arb: priority select plus alignment masking. It is reused for the input-versus-pending compare.

Test Plan:
- Reset release, stall=0, ack every cycle -> BOOT writes 0x0; then instr_valid=1 with pc_next 0x4, 0x8, 0xC on consecutive cycles.
- pc_cur=0x100, ack delayed 3 cycles -> imem_addr=0x100 stable for 4 cycles; pc_we=1 only on the ack cycle, with pc_next=0x104.
- In FETCH with no ack, branch_taken to 0x200 at cycle 1 and trap_req with trap_vec 0x80 at cycle 2; ack at cycle 4 -> flush pulses at cycles 1 and 2; on ack pc_next=0x80, instr_valid=0.
- No ack for 16 cycles with trap_vec=0x43 -> at cycle 16, fetch_fault=1, pc_next=0x40, pc_we=1.
- stall=1 on the ack cycle at pc 0x20, released 2 cycles later -> pc_we=0, state goes to IDLE, refetch from 0x20; no PC advance.
- rst asserted low mid-FETCH -> imem_req drops immediately; after release, BOOT writes RESET_VEC with pending cleared.
